cl_axi_slv_mem: RTL and testbench

- AXI4 responder (slave) that terminates single-beat and INCR-burst read/write transactions into an internal flop-based memory of 2^DEPTH_LOG2 entries, each 512 bits wide.
- Sits on a master port of the PCIS AXI interconnect, or directly behind an AXI master command engine, as a self-checking target for host and CL-initiated accesses.
- Write and read channels are independent and may operate concurrently.

---
 rtl/cl_axi_slv_mem.sv | 159 +++++++++++++++
 tb/tb_cl_axi_slv_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cl_axi_slv_mem.sv
// AXI4 responder backed by a 2^DEPTH_LOG2 x 512-bit flop memory.
// Independent write and read FSMs, one outstanding transaction per direction.
module cl_axi_slv_mem #(
    parameter int DEPTH_LOG2 = 6,
    parameter int ID_WIDTH   = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [63:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic                awvalid,
    output logic                awready,
    input  logic [511:0]        wdata,
    input  logic [63:0]         wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [63:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [511:0]        rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

    wr_state_t r_wr_state, w_wr_next;
    rd_state_t r_rd_state, w_rd_next;

    logic                  r_out_en;
    logic [DEPTH_LOG2-1:0] r_wr_idx, r_rd_idx;
    logic [7:0]            r_wr_cnt, r_rd_cnt;
    logic [ID_WIDTH-1:0]   r_bid, r_rid;
    logic [1:0]            r_bresp;
    logic [511:0]          r_rdata;
    logic [511:0]          r_mem [DEPTH];

    logic                  w_aw_hs, w_w_hs, w_w_end, w_ar_hs, w_r_hs, w_r_end;
    logic [DEPTH_LOG2-1:0] w_aw_idx, w_ar_idx;
    logic                  w_unused;

    assign w_aw_idx = awaddr[DEPTH_LOG2+5:6];
    assign w_ar_idx = araddr[DEPTH_LOG2+5:6];
    assign w_unused = &{1'b0, awsize, arsize, awaddr[63:DEPTH_LOG2+6], awaddr[5:0],
                        araddr[63:DEPTH_LOG2+6], araddr[5:0]};

    // r_out_en holds the readies low for the first cycle after reset release.
    assign awready = r_out_en && (r_wr_state == WR_IDLE);
    assign wready  = r_out_en && (r_wr_state == WR_DATA);
    assign bvalid  = r_out_en && (r_wr_state == WR_RESP);
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_out_en && (r_rd_state == RD_IDLE);
    assign rvalid  = r_out_en && (r_rd_state == RD_DATA);
    assign rlast   = rvalid && (r_rd_cnt == '0);
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = '0;

    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_w_end = w_w_hs && (wlast || (r_wr_cnt == '0));
    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rvalid && rready;
    assign w_r_end = w_r_hs && (r_rd_cnt == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_out_en   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
            r_out_en   <= 1'b1;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_aw_hs) w_wr_next = WR_DATA;
            WR_DATA: if (w_w_end) w_wr_next = WR_RESP;
            WR_RESP: if (bvalid && bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs) w_rd_next = RD_DATA;
            RD_DATA: if (w_r_end) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_idx <= '0;
            r_wr_cnt <= '0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else if (w_aw_hs) begin
            r_wr_idx <= w_aw_idx;
            r_wr_cnt <= awlen;
            r_bid    <= awid;
        end else if (w_w_hs) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            r_wr_cnt <= r_wr_cnt - 8'd1;
            if (w_w_end)
                r_bresp <= (wlast && (r_wr_cnt == '0)) ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_w_hs) begin
            for (int unsigned i = 0; i < 64; i++) begin
                if (wstrb[i]) r_mem[r_wr_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read register samples r_mem before any same-edge write lands (old data).
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_idx <= '0;
            r_rd_cnt <= '0;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rd_idx <= w_ar_idx + 1'b1;
            r_rd_cnt <= arlen;
            r_rid    <= arid;
            r_rdata  <= r_mem[w_ar_idx];
        end else if (w_r_hs && !w_r_end) begin
            r_rd_idx <= r_rd_idx + 1'b1;
            r_rd_cnt <= r_rd_cnt - 8'd1;
            r_rdata  <= r_mem[r_rd_idx];
        end
    end

endmodule

// File: tb/tb_cl_axi_slv_mem.sv
// Directed bench for cl_axi_slv_mem: bursts, wrap, backpressure, SLVERR,
// same-edge read/write ordering, partial strobes and mid-burst reset.
module tb_cl_axi_slv_mem;

    logic         aclk, aresetn;
    logic [15:0]  awid, bid, arid, rid;
    logic [63:0]  awaddr, araddr, wstrb;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [511:0] wdata, rdata;
    logic [1:0]   bresp, rresp;

    int checks = 0;
    int failures = 0;

    logic [511:0] wq [16];
    logic [511:0] rq [16];
    logic [63:0]  wstrb_g;
    logic [511:0] rmask;

    cl_axi_slv_mem #(.DEPTH_LOG2(6), .ID_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd6; awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("aw_timeout", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int nbeats, input int lastb);
        do_aw(id, addr, len);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wdata = wq[i]; wstrb = wstrb_g; wlast = (i == lastb); wvalid = 1'b1;
            while (!wready && n < 50) begin tick(); n++; end
            if (n >= 50) chk("w_timeout", wready, 1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_lat", bvalid, 1);
    endtask

    task automatic do_b(input logic [15:0] id, input logic [1:0] resp, input int stall);
        for (int i = 0; i < stall; i++) begin
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, resp);
            chk("bid_hold", bid, id);
            tick();
        end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, resp);
        chk("bid", bid, id);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clr", bvalid, 0);
        chk("awready_ret", awready, 1);
    endtask

    task automatic do_ar(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd6; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("ar_timeout", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("rd_lat", rvalid, 1);
    endtask

    task automatic do_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [3:0] pat);
        int beat = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [511:0] held = '0;
        logic held_last = 1'b0;
        do_ar(id, addr, len);
        while (beat <= int'(len) && cyc < 200) begin
            rready = pat[cyc % 4];
            if (stalled) begin
                chk("rdata_hold", rdata, held);
                chk("rlast_hold", rlast, held_last);
            end
            if (rready) begin
                chk("rvalid", rvalid, 1);
                chk("rdata", rdata & rmask, rq[beat] & rmask);
                chk("rlast", rlast, (beat == int'(len)));
                chk("rid", rid, id);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = rdata;
                held_last = rlast;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 200) chk("rd_timeout", beat, len + 1);
        chk("rvalid_end", rvalid, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
        wstrb_g = '1; rmask = '1;
        repeat (3) tick();
        chk("rst_outs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast}, '0);
        chk("rst_rdata", rdata, '0);
        aresetn = 1'b1;
        chk("rdy_after_rel", {awready, arready}, 2'b00);
        tick();
        chk("rdy_first_cycle", {awready, arready}, 2'b11);

        // single beat, 4-byte strobe
        wq[0] = 512'hDEADBEEF; wstrb_g = 64'hF;
        do_write(16'h1234, 64'h40, 8'd0, 1, 0);
        do_b(16'h1234, 2'b00, 0);
        wstrb_g = '1; rmask = 512'hFFFF_FFFF; rq[0] = 512'hDEADBEEF;
        do_read(16'h0ABC, 64'h40, 8'd0, 4'hF);
        rmask = '1;

        // 4-beat burst wrapping 62,63,0,1
        for (int i = 0; i < 4; i++) begin wq[i] = 512'(i + 1); rq[i] = 512'(i + 1); end
        do_write(16'h5, 64'hF80, 8'd3, 4, 3);
        do_b(16'h5, 2'b00, 0);
        do_read(16'h6, 64'hF80, 8'd3, 4'hF);
        rq[0] = 512'd3;
        do_read(16'h7, 64'h1000, 8'd0, 4'hF);

        // backpressure on B and R
        for (int i = 0; i < 8; i++) begin wq[i] = 512'(100 + i); rq[i] = 512'(100 + i); end
        do_write(16'h11, 64'h280, 8'd7, 8, 7);
        do_b(16'h11, 2'b00, 5);
        do_read(16'h12, 64'h280, 8'd7, 4'b1001);

        // early wlast
        wq[0] = 512'h21; wq[1] = 512'h22;
        do_write(16'h8, 64'h800, 8'd3, 2, 1);
        do_b(16'h8, 2'b10, 0);
        rq[0] = 512'h21; rq[1] = 512'h22;
        do_read(16'h9, 64'h800, 8'd1, 4'hF);

        // wlast never asserted
        wq[0] = 512'h31; wq[1] = 512'h32;
        do_write(16'hA, 64'h900, 8'd1, 2, -1);
        chk("wready_after_cnt", wready, 0);
        do_b(16'hA, 2'b10, 0);

        // same-edge write and read of index 5
        wq[0] = 512'h55;
        do_write(16'h1, 64'h140, 8'd0, 1, 0);
        do_b(16'h1, 2'b00, 0);
        do_aw(16'h2, 64'h140, 8'd0);
        wdata = 512'hAA; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
        arid = 16'h3; araddr = 64'h140; arlen = 8'd0; arvalid = 1'b1;
        chk("cc_ready", {wready, arready}, 2'b11);
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk("cc_old", rdata, 512'h55);
        chk("cc_valid", {rvalid, bvalid}, 2'b11);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        chk("cc_done", {rvalid, bvalid}, 2'b00);
        rq[0] = 512'hAA;
        do_read(16'h4, 64'h140, 8'd0, 4'hF);

        // partial strobe
        wq[0] = 512'h11223344;
        do_write(16'hB, 64'h1C0, 8'd0, 1, 0);
        do_b(16'hB, 2'b00, 0);
        wq[0] = 512'hAA; wstrb_g = 64'h1;
        do_write(16'hC, 64'h1C0, 8'd0, 1, 0);
        do_b(16'hC, 2'b00, 0);
        wstrb_g = '1; rq[0] = 512'h112233AA;
        do_read(16'hD, 64'h1C0, 8'd0, 4'hF);

        // reset in the middle of an 8-beat read
        do_ar(16'h21, 64'h280, 8'd7);
        rready = 1'b1;
        repeat (3) tick();
        chk("mid_rdata", rdata, 512'd103);
        aresetn = 1'b0; rready = 1'b0;
        tick();
        chk("mrst_outs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast}, '0);
        chk("mrst_rdata", rdata, '0);
        aresetn = 1'b1;
        chk("mrst_rdy0", arready, 0);
        tick();
        chk("mrst_rdy1", arready, 1);
        for (int i = 0; i < 8; i++) rq[i] = 512'(100 + i);
        do_read(16'h22, 64'h280, 8'd7, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
